bgm_operand_loader: RTL

//  Upstream feeder for the bgm floating-point datapath. Assembles 8-word operand frames from a
//  32-bit valid/ready stream into a ping-pong buffer and launches each frame to bgm as one

---
 rtl/bgm_operand_loader.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bgm_operand_loader.sv
// bgm_operand_loader: collects 8-word operand frames from a valid/ready stream
// into a two-bank ping-pong buffer. It launches each complete frame to the bgm
// datapath as one parallel operand set. A launch-tag shift register pairs each
// launch with the bgm result that comes back LATENCY cycles later.
module bgm_operand_loader #(
    parameter int BITS    = 32,
    parameter int LATENCY = 20
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [BITS-1:0] s_data,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            s_ready,
    input  logic            launch_en,
    output logic [BITS-1:0] Fn,
    output logic [BITS-1:0] sigma_a,
    output logic [BITS-1:0] sigma_b,
    output logic [BITS-1:0] sigma_c,
    output logic [BITS-1:0] dw_x,
    output logic [BITS-1:0] dw_y,
    output logic [BITS-1:0] dw_z,
    output logic [BITS-1:0] dt,
    output logic            launch,
    input  logic [BITS-1:0] res_in,
    output logic [BITS-1:0] m_data,
    output logic            m_valid,
    output logic            err_frame,
    input  logic            err_clr,
    output logic [15:0]     launch_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LAUNCH = 1'b1
    } state_t;

    state_t            state;
    logic [BITS-1:0]   bank_mem [2][8];
    logic [1:0]        bank_full;
    logic [1:0]        full_next;
    logic              fill_ptr;
    logic              launch_ptr;
    logic [2:0]        word_idx;
    logic [BITS-1:0]   op_reg [8];
    logic [LATENCY-1:0] tag_pipe;

    logic accept;
    logic idx_last;
    logic frame_close;
    logic frame_err;
    logic launch_from_full;
    logic launch_from_close;
    logic start_launch;
    logic free_bank;

    assign accept   = s_valid & s_ready;
    assign idx_last = (word_idx == 3'd7);
    assign frame_close = accept & s_last & idx_last;
    assign frame_err   = accept & (s_last != idx_last);

    // The oldest bank is either already full or is being closed at this very
    // edge; the latter lets a frame launch in the cycle right after its last word.
    assign launch_from_full  = bank_full[launch_ptr];
    assign launch_from_close = ~bank_full[launch_ptr] & frame_close;
    assign start_launch = (state == IDLE) & launch_en & (launch_from_full | launch_from_close);
    assign free_bank    = (state == LAUNCH);

    assign Fn      = op_reg[0];
    assign sigma_a = op_reg[1];
    assign sigma_b = op_reg[2];
    assign sigma_c = op_reg[3];
    assign dw_x    = op_reg[4];
    assign dw_y    = op_reg[5];
    assign dw_z    = op_reg[6];
    assign dt      = op_reg[7];

    // Next bank occupancy: a closing frame fills its bank, the launch cycle frees the oldest.
    always_comb begin
        full_next = bank_full;
        if (frame_close) begin
            full_next[fill_ptr] = 1'b1;
        end
        if (free_bank) begin
            full_next[launch_ptr] = 1'b0;
        end
    end

    // Frame storage; error words are not written so a dropped frame leaves no trace.
    always_ff @(posedge clock) begin
        if (accept && !frame_err) begin
            bank_mem[fill_ptr][word_idx] <= s_data;
        end
    end

    // Fill side bookkeeping: word index, bank pointers, ready and the sticky framing error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_full  <= 2'b00;
            fill_ptr   <= 1'b0;
            launch_ptr <= 1'b0;
            word_idx   <= 3'd0;
            s_ready    <= 1'b1;
            err_frame  <= 1'b0;
        end else begin
            bank_full <= full_next;
            s_ready   <= ~(full_next[0] & full_next[1]);
            if (frame_close) begin
                fill_ptr <= ~fill_ptr;
            end
            if (free_bank) begin
                launch_ptr <= ~launch_ptr;
            end
            if (accept) begin
                word_idx <= (frame_err || frame_close) ? 3'd0 : word_idx + 3'd1;
            end
            err_frame <= frame_err | (err_frame & ~err_clr);
        end
    end

    // Launch FSM: one LAUNCH cycle per frame, operands and strobe registered on entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            launch       <= 1'b0;
            launch_count <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                op_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_launch) begin
                        state        <= LAUNCH;
                        launch       <= 1'b1;
                        launch_count <= launch_count + 16'd1;
                        for (int i = 0; i < 8; i++) begin
                            op_reg[i] <= (launch_from_close && i == 7) ? s_data
                                                                       : bank_mem[launch_ptr][i];
                        end
                    end else begin
                        launch <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    launch <= 1'b0;
                end
            endcase
        end
    end

    // Result tagging: a launch bit travels LATENCY stages, then the bgm result is captured.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_pipe <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
        end else begin
            tag_pipe <= {tag_pipe[LATENCY-2:0], launch};
            m_valid  <= tag_pipe[LATENCY-1];
            if (tag_pipe[LATENCY-1]) begin
                m_data <= res_in;
            end
        end
    end

endmodule
